sync_r2w_level: RTL and testbench

SYNC_R2W_LEVEL -- requirements
Module: sync_r2w_level

---
 rtl/sync_r2w_level_pkg.sv | 12 +
 rtl/sync_r2w_level_gray2bin.sv | 14 +
 rtl/sync_r2w_level.sv | 134 +++++++++++++
 tb/tb_sync_r2w_level.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_r2w_level_pkg.sv
// Shared FIFO package: default geometry and the pointer-integrity error state type.
package sync_r2w_level_pkg;

   localparam int DEF_ASIZE     = 4;
   localparam int DEF_AF_THRESH = 12;

   typedef enum logic {
      OK  = 1'b0,
      ERR = 1'b1
   } errState_t;

endpackage

// File: rtl/sync_r2w_level_gray2bin.sv
// Purely combinational Gray-to-binary converter: each binary bit is the XOR
// of all Gray bits at and above its position.
module gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[WIDTH-1:i];
   end

endmodule

// File: rtl/sync_r2w_level.sv
// Read-to-write pointer synchronizer with registered occupancy, almost-full and
// sticky pointer-integrity error. Define SYNC_R2W_3STAGE_EN for a 3-flop chain.
module sync_r2w_level
   import sync_r2w_level_pkg::*;
#(
   parameter int ASIZE     = DEF_ASIZE,
   parameter int AF_THRESH = DEF_AF_THRESH
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic [ASIZE:0]   rptr,
   input  logic [ASIZE:0]   wptr,
   input  logic             err_clr,
   output logic [ASIZE:0]   rsw2_ptr,
   output logic [ASIZE:0]   wlevel,
   output logic             walmost_full,
   output logic             wptr_err
);

`ifdef SYNC_R2W_3STAGE_EN
   localparam int SYNC_STAGES = 3;
`else
   localparam int SYNC_STAGES = 2;
`endif
   localparam logic [2:0]     WARM_DONE  = 3'(SYNC_STAGES + 1);
   localparam logic [ASIZE:0] FULL_LEVEL = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] AF_LEVEL   = (ASIZE + 1)'(AF_THRESH);

   logic [ASIZE:0] r_rq1;
   logic [ASIZE:0] r_rsw2;
   logic [ASIZE:0] r_rprev;
   logic [ASIZE:0] r_wlevel;
   logic           r_walmostFull;
   logic [2:0]     r_warm;
   errState_t      r_state;
   logic           r_wptrErr;

   logic [ASIZE:0] w_rbin;
   logic [ASIZE:0] w_wbin;
   logic [ASIZE:0] w_rawDiff;
   logic [ASIZE:0] w_nextLevel;
   logic           w_levelErr;
   logic           w_ptrErr;
   logic           w_errCond;

`ifdef SYNC_R2W_3STAGE_EN
   logic [ASIZE:0] r_rq2;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_rq1  <= '0;
         r_rq2  <= '0;
         r_rsw2 <= '0;
      end else begin
         r_rq1  <= rptr;
         r_rq2  <= r_rq1;
         r_rsw2 <= r_rq2;
      end
   end
`else
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_rq1  <= '0;
         r_rsw2 <= '0;
      end else begin
         r_rq1  <= rptr;
         r_rsw2 <= r_rq1;
      end
   end
`endif

   gray2bin #(.WIDTH(ASIZE + 1)) u_rbin (.i_gray(r_rsw2), .o_bin(w_rbin));
   gray2bin #(.WIDTH(ASIZE + 1)) u_wbin (.i_gray(wptr),   .o_bin(w_wbin));

   assign w_rawDiff = w_wbin - w_rbin;

   // The integrity check stays masked until rprev holds a real synchronized
   // sample, so a nonzero rptr at reset release is not mistaken for a jump.
   always_comb begin
      w_levelErr  = (w_rawDiff > FULL_LEVEL);
      w_nextLevel = w_levelErr ? FULL_LEVEL : w_rawDiff;
      w_ptrErr    = (r_warm == WARM_DONE) && ($countones(r_rsw2 ^ r_rprev) > 1);
      w_errCond   = w_levelErr || w_ptrErr;
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_rprev       <= '0;
         r_wlevel      <= '0;
         r_walmostFull <= 1'b0;
         r_warm        <= '0;
      end else begin
         r_rprev       <= r_rsw2;
         r_wlevel      <= w_nextLevel;
         r_walmostFull <= (w_nextLevel >= AF_LEVEL);
         if (r_warm != WARM_DONE) begin
            r_warm <= r_warm + 3'd1;
         end
      end
   end

   // Set wins over err_clr when both arrive in the same cycle.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state   <= OK;
         r_wptrErr <= 1'b0;
      end else begin
         case (r_state)
            OK: begin
               if (w_errCond) begin
                  r_state   <= ERR;
                  r_wptrErr <= 1'b1;
               end
            end
            ERR: begin
               if (err_clr && !w_errCond) begin
                  r_state   <= OK;
                  r_wptrErr <= 1'b0;
               end
            end
            default: begin
               r_state   <= OK;
               r_wptrErr <= 1'b0;
            end
         endcase
      end
   end

   assign rsw2_ptr     = r_rsw2;
   assign wlevel       = r_wlevel;
   assign walmost_full = r_walmostFull;
   assign wptr_err     = r_wptrErr;

endmodule

// File: tb/tb_sync_r2w_level.sv
// Directed self-checking bench for sync_r2w_level (ASIZE=4, AF_THRESH=12);
// follows SYNC_R2W_3STAGE_EN to pick the expected synchronizer depth.
module tb_sync_r2w_level;

`ifdef SYNC_R2W_3STAGE_EN
   localparam int S = 3;
`else
   localparam int S = 2;
`endif

   logic       wclk;
   logic       wrst_n;
   logic [4:0] rptr;
   logic [4:0] wptr;
   logic       err_clr;
   logic [4:0] rsw2_ptr;
   logic [4:0] wlevel;
   logic       walmost_full;
   logic       wptr_err;

   int checks;
   int errors;

   sync_r2w_level #(.ASIZE(4), .AF_THRESH(12)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .rptr         (rptr),
      .wptr         (wptr),
      .err_clr      (err_clr),
      .rsw2_ptr     (rsw2_ptr),
      .wlevel       (wlevel),
      .walmost_full (walmost_full),
      .wptr_err     (wptr_err)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray(input int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] rp, input logic [4:0] wp,
                                input logic clr);
      rptr    = rp;
      wptr    = wp;
      err_clr = clr;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge wclk);
         #1;
      end
   endtask

   // Assert reset between edges, confirm outputs clear at once, hold one edge.
   task automatic doReset(input logic [4:0] rp, input logic [4:0] wp);
      wrst_n = 1'b0;
      #1;
      checkOutput("rst_now_rsw2", rsw2_ptr, 0);
      checkOutput("rst_now_level", wlevel, 0);
      checkOutput("rst_now_af", walmost_full, 0);
      checkOutput("rst_now_err", wptr_err, 0);
      applyStimulus(rp, wp, 1'b0);
      tick(1);
      checkOutput("rst_hold_level", wlevel, 0);
      checkOutput("rst_hold_rsw2", rsw2_ptr, 0);
      wrst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      checks = 0;
      errors = 0;
      wrst_n = 1'b0;
      applyStimulus(5'b00000, 5'b00000, 1'b0);
      #2;
      checkOutput("init_rsw2", rsw2_ptr, 0);
      checkOutput("init_level", wlevel, 0);
      checkOutput("init_af", walmost_full, 0);
      checkOutput("init_err", wptr_err, 0);
      tick(2);
      wrst_n = 1'b1;

      // Full occupancy: write pointer at binary 16, read pointer at 0.
      applyStimulus(5'b00000, 5'b11000, 1'b0);
      tick(1);
      checkOutput("full_wlat1", wlevel, 16);
      tick(S);
      checkOutput("full_level", wlevel, 16);
      checkOutput("full_af", walmost_full, 1);
      checkOutput("full_err", wptr_err, 0);

      // Almost-full threshold boundary.
      applyStimulus(5'b00000, gray(11), 1'b0);
      tick(1);
      checkOutput("thr11_level", wlevel, 11);
      checkOutput("thr11_af", walmost_full, 0);
      applyStimulus(5'b00000, gray(12), 1'b0);
      checkOutput("thr12_pre_level", wlevel, 11);
      checkOutput("thr12_pre_af", walmost_full, 0);
      tick(1);
      checkOutput("thr12_level", wlevel, 12);
      checkOutput("thr12_af", walmost_full, 1);

      // Walk both pointers in legal Gray steps through their MSB wrap.
      for (int r = 1; r <= 20; r++) begin
         applyStimulus(gray(r), gray(r + 12), 1'b0);
         tick(1);
      end
      tick(S);
      applyStimulus(5'b11110, 5'b00010, 1'b0);
      tick(1);
      checkOutput("wrap_rsw2", rsw2_ptr, 5'b11110);
      checkOutput("wrap_level", wlevel, 15);
      checkOutput("wrap_af", walmost_full, 1);
      checkOutput("wrap_err", wptr_err, 0);

      doReset(5'b00000, 5'b00000);

      // Integrity: a two-bit jump on the read pointer.
      applyStimulus(5'b00000, gray(4), 1'b0);
      tick(6);
      checkOutput("intg_base_err", wptr_err, 0);
      checkOutput("intg_base_level", wlevel, 4);
      applyStimulus(5'b00011, gray(4), 1'b0);
      tick(S);
      checkOutput("intg_pre_err", wptr_err, 0);
      tick(1);
      checkOutput("intg_set_err", wptr_err, 1);
      checkOutput("intg_level", wlevel, 2);
      tick(3);
      checkOutput("intg_sticky", wptr_err, 1);

      // A new jump coinciding with err_clr keeps the flag set.
      applyStimulus(5'b00000, gray(4), 1'b0);
      tick(S);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checkOutput("clr_vs_set", wptr_err, 1);
      tick(2);
      err_clr = 1'b1;
      checkOutput("clr_pre", wptr_err, 1);
      tick(1);
      err_clr = 1'b0;
      checkOutput("clr_ok", wptr_err, 0);

      // Illegal occupancy saturates and raises the error.
      applyStimulus(5'b00000, 5'b11110, 1'b0);
      tick(1);
      checkOutput("sat_level", wlevel, 16);
      checkOutput("sat_af", walmost_full, 1);
      checkOutput("sat_err", wptr_err, 1);
      applyStimulus(5'b00000, gray(4), 1'b0);
      tick(1);
      checkOutput("sat_back_level", wlevel, 4);
      checkOutput("sat_back_af", walmost_full, 0);
      checkOutput("sat_back_err", wptr_err, 1);

      // Reset with the error set, nonzero read pointer across release.
      doReset(5'b00011, gray(5));
      tick(6);
      checkOutput("warm_err", wptr_err, 0);
      checkOutput("warm_rsw2", rsw2_ptr, 5'b00011);
      checkOutput("warm_level", wlevel, 3);

      // Single read-pointer step: synchronizer and level latency.
      applyStimulus(5'b00010, gray(5), 1'b0);
      tick(S - 1);
      checkOutput("lat_rsw2_hold", rsw2_ptr, 5'b00011);
      tick(1);
      checkOutput("lat_rsw2", rsw2_ptr, 5'b00010);
      checkOutput("lat_level_hold", wlevel, 3);
      tick(1);
      checkOutput("lat_level", wlevel, 2);
      checkOutput("lat_err", wptr_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
